// File: rtl/rob_commit_pkg.sv
// Shared pipeline types (package pipTypes): ROB entry layout and the commit FSM state.
package pipTypes;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } commit_state_t;

  typedef struct packed {
    logic        dest_reg_valid;
    logic [4:0]  dest_reg;
    logic [31:0] result_lo;
    logic        is_store;
    logic        is_halt;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// Combinational retirement prefix: how many head entries retire this cycle and
// which lanes keep their register write after same-cycle WAW resolution.
module rob_commit_select
  import pipTypes::*;
#(
  parameter int DEPTHLOG2    = 4,
  parameter int EXT_COUNT    = 4,
  parameter int EXTCOUNTLOG2 = 2
) (
  input  logic [EXT_COUNT-1:0] is_store,
  input  logic [EXT_COUNT-1:0] is_halt,
  input  logic [EXT_COUNT-1:0] dest_valid,
  input  logic [4:0]           dest_reg [EXT_COUNT],
  input  logic [EXT_COUNT-1:0] slot_valid,
  input  logic [DEPTHLOG2:0]   used_count,
  input  logic                 run,
  input  logic                 st_ready,
  output logic [EXTCOUNTLOG2:0] n,
  output logic [EXT_COUNT-1:0] we_mask,
  output logic                 group_halt,
  output logic                 st_valid
);

  logic [EXT_COUNT-1:0] eligible;
  logic [EXT_COUNT-1:0] writes;
  logic                 stop;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      eligible[i] = run && slot_valid[i] && ((DEPTHLOG2+1)'(i) < used_count);
    end
  end

  assign st_valid = eligible[0] && is_store[0];

  // Stores only retire from lane 0 and always alone; a halt closes the group.
  always_comb begin
    n          = '0;
    group_halt = 1'b0;
    stop       = 1'b0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (!stop) begin
        if (!eligible[i]) begin
          stop = 1'b1;
        end else if (is_store[i]) begin
          if (i == 0 && st_ready) begin
            n          = (EXTCOUNTLOG2+1)'(1);
            group_halt = is_halt[i];
          end
          stop = 1'b1;
        end else begin
          n = (EXTCOUNTLOG2+1)'(i + 1);
          if (is_halt[i]) begin
            group_halt = 1'b1;
            stop       = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    writes = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      writes[i] = ((EXTCOUNTLOG2+1)'(i) < n) && dest_valid[i] && (dest_reg[i] != 5'd0);
    end
    we_mask = writes;
    for (int i = 0; i < EXT_COUNT; i++) begin
      for (int j = i + 1; j < EXT_COUNT; j++) begin
        if (writes[j] && dest_reg[j] == dest_reg[i]) we_mask[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// In-order ROB retirement stage: consume handshake, registered RF writes, store
// hand-off and halt FSM. Define COMMIT_STATS_EN to add 64-bit retirement counters.
module rob_commit
  import pipTypes::*;
#(
  parameter int DEPTH        = 16,
  parameter int EXT_COUNT    = 4,
  parameter int DEPTHLOG2    = $clog2(DEPTH),
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  rob_entry_t              slot_data [EXT_COUNT],
  input  logic [EXT_COUNT-1:0]    slot_valid,
  input  logic [DEPTHLOG2:0]      used_count,
  output logic                    consume,
  output logic [EXTCOUNTLOG2-1:0] consume_count,
  output logic [EXT_COUNT-1:0]    rf_we,
  output logic [4:0]              rf_waddr [EXT_COUNT],
  output logic [31:0]             rf_wdata [EXT_COUNT],
  output logic                    st_valid,
  input  logic                    st_ready,
  output logic [31:0]             st_addr,
  output logic [31:0]             st_data,
  output logic [3:0]              st_be,
  output logic                    halted,
`ifdef COMMIT_STATS_EN
  output logic [63:0]             stat_retired,
  output logic [63:0]             stat_stores,
  output logic [63:0]             stat_stall_cycles,
`endif
  input  logic                    resume
);

  // Handshake: consume/consume_count and st_valid/st_ready are evaluated from
  // this cycle's inputs and take effect at the next rising edge; a store moves
  // only when st_valid and st_ready are both high.
  commit_state_t state;

  logic [EXT_COUNT-1:0]  is_store;
  logic [EXT_COUNT-1:0]  is_halt;
  logic [EXT_COUNT-1:0]  dest_valid;
  logic [4:0]            dest_reg [EXT_COUNT];
  logic [EXTCOUNTLOG2:0] n;
  logic [EXT_COUNT-1:0]  we_mask;
  logic                  group_halt;

  always_comb begin
    for (int i = 0; i < EXT_COUNT; i++) begin
      is_store[i]   = slot_data[i].is_store;
      is_halt[i]    = slot_data[i].is_halt;
      dest_valid[i] = slot_data[i].dest_reg_valid;
      dest_reg[i]   = slot_data[i].dest_reg;
    end
  end

  rob_commit_select #(
    .DEPTHLOG2   (DEPTHLOG2),
    .EXT_COUNT   (EXT_COUNT),
    .EXTCOUNTLOG2(EXTCOUNTLOG2)
  ) u_select (
    .is_store  (is_store),
    .is_halt   (is_halt),
    .dest_valid(dest_valid),
    .dest_reg  (dest_reg),
    .slot_valid(slot_valid),
    .used_count(used_count),
    .run       (state == RUN),
    .st_ready  (st_ready),
    .n         (n),
    .we_mask   (we_mask),
    .group_halt(group_halt),
    .st_valid  (st_valid)
  );

  assign consume       = (n != '0);
  assign consume_count = consume ? EXTCOUNTLOG2'(n - (EXTCOUNTLOG2+1)'(1)) : '0;
  assign st_addr       = slot_data[0].st_addr;
  assign st_data       = slot_data[0].st_data;
  assign st_be         = slot_data[0].st_be;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: if (group_halt) begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        HALTED: if (resume) begin
          state  <= RUN;
          halted <= 1'b0;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_we <= '0;
      for (int i = 0; i < EXT_COUNT; i++) begin
        rf_waddr[i] <= 5'd0;
        rf_wdata[i] <= 32'd0;
      end
    end else begin
      rf_we <= we_mask;
      for (int i = 0; i < EXT_COUNT; i++) begin
        rf_waddr[i] <= slot_data[i].dest_reg;
        rf_wdata[i] <= slot_data[i].result_lo;
      end
    end
  end

`ifdef COMMIT_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_retired      <= 64'd0;
      stat_stores       <= 64'd0;
      stat_stall_cycles <= 64'd0;
    end else begin
      stat_retired <= stat_retired + 64'(n);
      if (st_valid && st_ready) stat_stores <= stat_stores + 64'd1;
      if (used_count != '0 && n == '0) stat_stall_cycles <= stat_stall_cycles + 64'd1;
    end
  end
`endif

endmodule
